// File: rtl/twiddle_multiplier_pipe.sv
// Three-stage complex multiplier x * W^k for SDF FFT stages, with optional twiddle
// conjugation (IFFT), round-half-up or floor scaling, and saturate-or-wrap with overflow flag.
module twiddle_multiplier_pipe #(
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int NFFT         = 64,
  parameter int ROUND_MODE   = 1,
  parameter int SATURATE     = 1,
  parameter     TW_RE_FILE   = "tw_re.mem",
  parameter     TW_IM_FILE   = "tw_im.mem",
  localparam int DW          = INTEGER_SIZE + FRACT_SIZE,
  localparam int ADDR_W      = $clog2(NFFT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 inv,
  input  logic [ADDR_W-1:0]    address,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 overflow
);

  localparam int PW = 2 * DW;
  localparam int SW = PW + 1;
  localparam int RW = SW - FRACT_SIZE;
  localparam logic signed [SW-1:0] HALF =
    (ROUND_MODE != 0) ? (SW'(1) << (FRACT_SIZE - 1)) : '0;
  localparam logic [DW-1:0] MAX_W = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_W = {1'b1, {(DW-1){1'b0}}};

  // Twiddle table is evaluated at elaboration with the same rounding the .mem files
  // are generated with, so no file has to accompany the netlist.
  function automatic logic signed [DW-1:0] tw_word(input int k, input bit im);
    real ang, v;
    ang = 2.0 * 3.141592653589793 * real'(k) / real'(NFFT);
    v   = im ? -$sin(ang) : $cos(ang);
    return DW'(longint'(v * (2.0 ** FRACT_SIZE)));
  endfunction

  function automatic logic signed [RW-1:0] round_shift(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    t = s + HALF;
    return t[SW-1:FRACT_SIZE];
  endfunction

  // Returns {out_of_range, value}; range is judged on the full-precision scaled result.
  function automatic logic [DW:0] fit(input logic signed [RW-1:0] v);
    logic in_range;
    in_range = (&v[RW-1:DW-1]) | ~(|v[RW-1:DW-1]);
    if (in_range)
      return {1'b0, v[DW-1:0]};
    else if (SATURATE != 0)
      return {1'b1, (v[RW-1] ? MIN_W : MAX_W)};
    else
      return {1'b1, v[DW-1:0]};
  endfunction

  logic signed [DW-1:0] rom_re [NFFT];
  logic signed [DW-1:0] rom_im [NFFT];

  for (genvar g = 0; g < NFFT; g++) begin : g_rom
    assign rom_re[g] = tw_word(g, 1'b0);
    assign rom_im[g] = tw_word(g, 1'b1);
  end

  logic                 vld_p0, vld_p1;
  logic signed [DW-1:0] x_r_p0, x_i_p0, tw_r_p0, tw_i_p0;
  logic signed [PW-1:0] rr_p1, ii_p1, ri_p1, ir_p1;

  // Stage 1: capture sample and (optionally conjugated) twiddle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0  <= 1'b0;
      x_r_p0  <= '0;
      x_i_p0  <= '0;
      tw_r_p0 <= '0;
      tw_i_p0 <= '0;
    end else begin
      vld_p0  <= in_valid;
      x_r_p0  <= in_r;
      x_i_p0  <= in_i;
      tw_r_p0 <= rom_re[address];
      tw_i_p0 <= inv ? -rom_im[address] : rom_im[address];
    end
  end

  // Stage 2: four full-width partial products
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      rr_p1  <= '0;
      ii_p1  <= '0;
      ri_p1  <= '0;
      ir_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      rr_p1  <= PW'(x_r_p0) * PW'(tw_r_p0);
      ii_p1  <= PW'(x_i_p0) * PW'(tw_i_p0);
      ri_p1  <= PW'(x_r_p0) * PW'(tw_i_p0);
      ir_p1  <= PW'(x_i_p0) * PW'(tw_r_p0);
    end
  end

  logic signed [SW-1:0] sum_r, sum_i;
  logic [DW:0]          res_r, res_i;

  always_comb begin
    sum_r = SW'(rr_p1) - SW'(ii_p1);
    sum_i = SW'(ri_p1) + SW'(ir_p1);
    res_r = fit(round_shift(sum_r));
    res_i = fit(round_shift(sum_i));
  end

  // Stage 3: scaled, range-limited result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      out_r     <= res_r[DW-1:0];
      out_i     <= res_i[DW-1:0];
      overflow  <= vld_p1 & (res_r[DW] | res_i[DW]);
    end
  end

endmodule

// File: tb/tb_twiddle_multiplier_pipe.sv
// Directed + randomized check of twiddle_multiplier_pipe in two configurations
// (round+saturate, floor+wrap) against an arithmetic reference model.
module tb_twiddle_multiplier_pipe;
  localparam int IS = 6, FS = 12, NFFT = 64;
  localparam int DW = IS + FS, AW = $clog2(NFFT);

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, inv = 1'b0;
  logic [AW-1:0] address = '0;
  logic signed [DW-1:0] in_r = '0, in_i = '0;
  logic out_valid_a, ovf_a, out_valid_b, ovf_b;
  logic signed [DW-1:0] out_r_a, out_i_a, out_r_b, out_i_b;

  int n_cmp = 0, n_bad = 0;

  typedef struct { bit v; longint r; longint i; bit ov; } exp_t;
  exp_t pa[3], pb[3];

  always #5 clk = ~clk;

  twiddle_multiplier_pipe #(.INTEGER_SIZE(IS), .FRACT_SIZE(FS), .NFFT(NFFT),
                            .ROUND_MODE(1), .SATURATE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inv(inv), .address(address),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid_a), .out_r(out_r_a),
    .out_i(out_i_a), .overflow(ovf_a));

  twiddle_multiplier_pipe #(.INTEGER_SIZE(IS), .FRACT_SIZE(FS), .NFFT(NFFT),
                            .ROUND_MODE(0), .SATURATE(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inv(inv), .address(address),
    .in_r(in_r), .in_i(in_i), .out_valid(out_valid_b), .out_r(out_r_b),
    .out_i(out_i_b), .overflow(ovf_b));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // y = x * W^k with W = exp(-j2pi/NFFT), conjugated for inv, scaled by 2^-FS.
  function automatic exp_t model(input bit v, input bit iv, input int k,
                                 input longint ar, input longint ai,
                                 input bit rm, input bit sat);
    exp_t e;
    real ang;
    longint tr, ti, pr, pi, lo, hi;
    bit o;
    logic signed [DW-1:0] w;
    ang = 2.0 * 3.141592653589793 * real'(k) / real'(NFFT);
    tr = longint'($cos(ang) * (2.0 ** FS));
    ti = -longint'($sin(ang) * (2.0 ** FS));
    if (iv) ti = -ti;
    pr = ar * tr - ai * ti;
    pi = ar * ti + ai * tr;
    if (rm) begin
      pr += longint'(1) <<< (FS - 1);
      pi += longint'(1) <<< (FS - 1);
    end
    pr = pr >>> FS;
    pi = pi >>> FS;
    lo = -(longint'(1) <<< (DW - 1));
    hi = -lo - 1;
    o = (pr < lo) || (pr > hi) || (pi < lo) || (pi > hi);
    if (sat) begin
      if (pr < lo) pr = lo; else if (pr > hi) pr = hi;
      if (pi < lo) pi = lo; else if (pi > hi) pi = hi;
    end else begin
      w = pr[DW-1:0]; pr = w;
      w = pi[DW-1:0]; pi = w;
    end
    e.v = v; e.r = pr; e.i = pi; e.ov = v && o;
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e, input logic v,
                           input logic signed [DW-1:0] r, input logic signed [DW-1:0] i,
                           input logic o);
    chk({tag, ".valid"}, v, e.v);
    if (e.v) begin
      chk({tag, ".re"}, r, e.r);
      chk({tag, ".im"}, i, e.i);
    end
    chk({tag, ".ovf"}, o, e.ov);
  endtask

  task automatic clear_model();
    for (int s = 0; s < 3; s++) begin
      pa[s] = '{default: 0};
      pb[s] = '{default: 0};
    end
  endtask

  task automatic tick();
    for (int s = 2; s > 0; s--) begin
      pa[s] = pa[s-1];
      pb[s] = pb[s-1];
    end
    pa[0] = model(in_valid, inv, int'(address), longint'(in_r), longint'(in_i), 1'b1, 1'b1);
    pb[0] = model(in_valid, inv, int'(address), longint'(in_r), longint'(in_i), 1'b0, 1'b0);
    @(posedge clk); #1;
    check_out("a", pa[2], out_valid_a, out_r_a, out_i_a, ovf_a);
    check_out("b", pb[2], out_valid_b, out_r_b, out_i_b, ovf_b);
  endtask

  task automatic send(input bit iv, input int k, input longint r, input longint i);
    in_valid = 1'b1; inv = iv; address = AW'(k);
    in_r = DW'(r); in_i = DW'(i);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0; inv = 1'($urandom); address = AW'($urandom);
    in_r = DW'($urandom); in_i = DW'($urandom);
    tick();
  endtask

  initial begin
    clear_model();
    #1;
    chk("reset.valid", out_valid_a, 0);
    chk("reset.re", out_r_a, 0);
    chk("reset.im", out_i_a, 0);
    chk("reset.ovf", ovf_a, 0);
    tick(); tick();
    rst = 1'b1;
    idle(); idle();

    // identity twiddle, exactly 3 cycles of latency
    send(1'b0, 0, 1000, -500);
    idle(); idle();
    chk("k0.valid", out_valid_a, 1);
    chk("k0.re", out_r_a, 1000);
    chk("k0.im", out_i_a, -500);
    idle(); idle();

    // -j forward then +j inverse, back to back
    send(1'b0, 16, 1000, -500);
    send(1'b1, 16, 1000, -500);
    idle();
    chk("k16.fwd.re", out_r_a, -500);
    chk("k16.fwd.im", out_i_a, -1000);
    idle();
    chk("k16.inv.valid", out_valid_a, 1);
    chk("k16.inv.re", out_r_a, 500);
    chk("k16.inv.im", out_i_a, 1000);
    idle();

    // 45 degrees, rounding vs floor on a 1-LSB input
    send(1'b0, 8, 4096, 0);
    send(1'b0, 8, 1, 0);
    idle();
    chk("k8.unit.re", out_r_a, 2896);
    chk("k8.unit.im", out_i_a, -2896);
    idle();
    chk("k8.lsb.round.re", out_r_a, 1);
    chk("k8.lsb.round.im", out_i_a, -1);
    chk("k8.lsb.floor.re", out_r_b, 0);
    chk("k8.lsb.floor.im", out_i_b, -1);
    idle();

    // full-scale overflow: clamp vs wrap
    send(1'b0, 8, 131071, 131071);
    idle(); idle();
    chk("sat.re", out_r_a, 131071);
    chk("sat.im", out_i_a, 0);
    chk("sat.ovf", ovf_a, 1);
    chk("wrap.re", out_r_b, -76802);
    chk("wrap.ovf", ovf_b, 1);
    idle();
    chk("sat.ovf.next", ovf_a, 0);

    // most negative input
    send(1'b0, 16, -131072, -131072);
    idle(); idle();
    chk("minneg.re", out_r_a, -131072);
    chk("minneg.im", out_i_a, 131071);
    chk("minneg.ovf", ovf_a, 1);
    idle(); idle();

    // full-rate random stream over every address
    for (int k = 0; k < NFFT; k++)
      send(1'($urandom), k, longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))));
    idle(); idle(); idle(); idle();

    // asynchronous reset with samples in flight
    send(1'b0, 5, 12345, -6789);
    send(1'b1, 9, -4000, 777);
    send(1'b0, 40, 90000, 90000);
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("arst.valid.a", out_valid_a, 0);
    chk("arst.re.a", out_r_a, 0);
    chk("arst.im.a", out_i_a, 0);
    chk("arst.valid.b", out_valid_b, 0);
    chk("arst.ovf.a", ovf_a, 0);
    clear_model();
    @(posedge clk); #1;
    chk("arst.hold.valid", out_valid_a, 0);
    rst = 1'b1;
    idle(); idle(); idle(); idle();
    send(1'b1, 33, -20000, 15000);
    idle(); idle(); idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
